// File: rtl/ro_rng_pkg.sv
// Shared types and width helpers for the ring-oscillator sample collector.
package ro_rng_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    WAIT    = 1'b1
  } ro_col_state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ro_sync_chain.sv
// Multi-flop synchroniser for one free-running oscillator line.
module ro_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else if (clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ro_sample_collector.sv
// Samples and XOR-folds NUM_RO oscillators, packs raw bits into words on a
// valid/ready port and flags a stuck entropy source via a repetition count.
module ro_sample_collector
  import ro_rng_pkg::*;
#(
  parameter int NUM_RO      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WORD_W      = 32,
  parameter int DECIM       = 1,
  parameter int STUCK_LIM   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              stuck
);

  localparam int DEC_W = cnt_width(DECIM);
  localparam int BIT_W = cnt_width(WORD_W);
  localparam int REP_W = cnt_width(STUCK_LIM + 1);

  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [REP_W-1:0] REP_LIM  = REP_W'(STUCK_LIM);

  logic [NUM_RO-1:0] sync_out;
  logic              raw_bit;
  logic              strobe;
  logic              out_free;
  logic              handshake;
  logic [WORD_W-1:0] full_word_d;
  logic [REP_W-1:0]  rep_cnt_d;

  ro_col_state_t     state_q;
  logic [DEC_W-1:0]  dec_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [WORD_W-1:0] shreg_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic              last_bit_q;
  logic [WORD_W-1:0] word_out_q;
  logic              word_valid_q;
  logic              stuck_q;

  for (genvar i = 0; i < NUM_RO; i++) begin : g_sync
    ro_sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .d  (ro_in[i]),
      .q  (sync_out[i])
    );
  end

  assign raw_bit     = ^sync_out;
  assign strobe      = en && (dec_cnt_q == DEC_LAST);
  assign out_free    = !word_valid_q || word_ready;
  assign handshake   = word_valid_q && word_ready;
  assign full_word_d = {shreg_q[WORD_W-2:0], raw_bit};

  // NOTE: default first so every path assigns rep_cnt_d and no latch is inferred.
  always_comb begin
    rep_cnt_d = REP_W'(1);
    if (raw_bit == last_bit_q) begin
      rep_cnt_d = (rep_cnt_q == REP_LIM) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      dec_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      rep_cnt_q    <= '0;
      last_bit_q   <= 1'b0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      stuck_q      <= 1'b0;
    end else if (clr) begin
      state_q      <= COLLECT;
      dec_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      rep_cnt_q    <= '0;
      last_bit_q   <= 1'b0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      if (strobe) begin
        dec_cnt_q <= '0;
      end else if (en) begin
        dec_cnt_q <= dec_cnt_q + DEC_W'(1);
      end

      // A load later in this block overrides the consume.
      if (handshake) begin
        word_valid_q <= 1'b0;
      end

      unique case (state_q)
        COLLECT: begin
          if (strobe) begin
            shreg_q <= full_word_d;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              if (out_free) begin
                word_out_q   <= full_word_d;
                word_valid_q <= 1'b1;
              end else begin
                state_q <= WAIT;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        WAIT: begin
          if (out_free) begin
            word_out_q   <= shreg_q;
            word_valid_q <= 1'b1;
            state_q      <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase

      // Health runs on every strobe, including those discarded in WAIT.
      if (strobe) begin
        last_bit_q <= raw_bit;
        rep_cnt_q  <= rep_cnt_d;
        if (rep_cnt_d == REP_LIM) begin
          stuck_q <= 1'b1;
        end
      end
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign stuck      = stuck_q;

endmodule
